// File: rtl/dmem_arbiter_pkg.sv
// Shared bus widths, FSM encodings and burst default for the data-memory port arbiter.
// Bus widths match the DATA_ADDR_BUS / DATA_BUS / DATA_WE_BUS definitions used by the core.
package dmem_arbiter_pkg;

    localparam int DATA_ADDR_BUS         = 32;
    localparam int DATA_BUS              = 32;
    localparam int DATA_WE_BUS           = 4;
    localparam int STREAK_W              = 4;
    localparam int DEFAULT_MAX_CPU_BURST = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_BUSY = 2'd1,
        ST_EXT_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage and an external requester,
// running each access as a multi-cycle transaction completed by m_ready.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CPU_BURST = DEFAULT_MAX_CPU_BURST
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    input  logic                     cpu_dce,
    input  logic [DATA_ADDR_BUS-1:0] cpu_daddr,
    input  logic [DATA_WE_BUS-1:0]   cpu_we,
    input  logic [DATA_WE_BUS-1:0]   cpu_dre,
    input  logic [DATA_BUS-1:0]      cpu_din,
    output logic                     cpu_stall,
    output logic [DATA_BUS-1:0]      cpu_dout,
    input  logic                     ext_req,
    input  logic [DATA_ADDR_BUS-1:0] ext_addr,
    input  logic [DATA_WE_BUS-1:0]   ext_we,
    input  logic [DATA_BUS-1:0]      ext_wdata,
    output logic                     ext_ack,
    output logic [DATA_BUS-1:0]      ext_rdata,
    output logic                     m_ce,
    output logic [DATA_ADDR_BUS-1:0] m_addr,
    output logic [DATA_WE_BUS-1:0]   m_we,
    output logic [DATA_WE_BUS-1:0]   m_re,
    output logic [DATA_BUS-1:0]      m_wdata,
    input  logic [DATA_BUS-1:0]      m_rdata,
    input  logic                     m_ready,
    output arb_state_e               dbg_state
);

    // Handshakes: the external requester holds ext_req and its fields stable until the
    // one-cycle ext_ack; the CPU holds cpu_dce and its fields stable while cpu_stall=1;
    // the memory completes the access held on m_* by raising m_ready while m_ce=1.

    arb_state_e          state, state_next;
    logic [STREAK_W-1:0] streak;
    logic                ext_eligible;
    logic                burst_full;
    logic                grant_cpu;
    logic                grant_ext;
    logic                done_cpu;
    logic                done_ext;

    // The ack mask stops a request whose ack is still in flight from being served twice.
    assign ext_eligible = ext_req & ~ext_ack;
    assign burst_full   = (streak == STREAK_W'(MAX_CPU_BURST));
    assign done_cpu     = (state == ST_CPU_BUSY) & m_ready;
    assign done_ext     = (state == ST_EXT_BUSY) & m_ready;
    assign cpu_stall    = cpu_dce & ~done_cpu;
    assign dbg_state    = state;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_cpu  = 1'b0;
        grant_ext  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_dce && !(ext_eligible && burst_full)) begin
                    grant_cpu  = 1'b1;
                    state_next = ST_CPU_BUSY;
                end else if (ext_eligible) begin
                    grant_ext  = 1'b1;
                    state_next = ST_EXT_BUSY;
                end
            end
            ST_CPU_BUSY, ST_EXT_BUSY: begin
                if (m_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Streak only counts CPU grants that actually kept a waiting external request out.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            streak <= '0;
        end else if (!ext_req || grant_ext) begin
            streak <= '0;
        end else if (grant_cpu && (streak != {STREAK_W{1'b1}})) begin
            streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            m_ce    <= 1'b0;
            m_addr  <= '0;
            m_we    <= '0;
            m_re    <= '0;
            m_wdata <= '0;
        end else if (grant_cpu) begin
            m_ce    <= 1'b1;
            m_addr  <= cpu_daddr;
            m_we    <= cpu_we;
            m_re    <= cpu_dre;
            m_wdata <= cpu_din;
        end else if (grant_ext) begin
            m_ce    <= 1'b1;
            m_addr  <= ext_addr;
            m_we    <= ext_we;
            m_re    <= (ext_we == '0) ? {DATA_WE_BUS{1'b1}} : '0;
            m_wdata <= ext_wdata;
        end else if (done_cpu || done_ext) begin
            m_ce    <= 1'b0;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cpu_dout  <= '0;
            ext_ack   <= 1'b0;
            ext_rdata <= '0;
        end else begin
            ext_ack <= done_ext;
            if (done_cpu) begin
                cpu_dout <= m_rdata;
            end
            if (done_ext) begin
                ext_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: wait-state memory model, grant/completion scoreboards.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cpu_dce;
    logic [31:0] cpu_daddr;
    logic [3:0]  cpu_we;
    logic [3:0]  cpu_dre;
    logic [31:0] cpu_din;
    logic        cpu_stall;
    logic [31:0] cpu_dout;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic [3:0]  ext_we;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic        m_ce;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [3:0]  m_re;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    arb_state_e  dbg_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wait_states = 0;
    int          grant_cnt = 0;
    int          ack_cnt = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_ext_q[$];

    dmem_arbiter #(.MAX_CPU_BURST(4)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n  (rst_n),
        .cpu_dce    (cpu_dce),
        .cpu_daddr  (cpu_daddr),
        .cpu_we     (cpu_we),
        .cpu_dre    (cpu_dre),
        .cpu_din    (cpu_din),
        .cpu_stall  (cpu_stall),
        .cpu_dout   (cpu_dout),
        .ext_req    (ext_req),
        .ext_addr   (ext_addr),
        .ext_we     (ext_we),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rdata  (ext_rdata),
        .m_ce       (m_ce),
        .m_addr     (m_addr),
        .m_we       (m_we),
        .m_re       (m_re),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ready    (m_ready),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- memory model + grant scoreboard ----------------
    initial begin
        int  wait_cnt;
        logic prev_ce;
        wait_cnt = 0;
        prev_ce  = 1'b0;
        m_ready  = 1'b0;
        m_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_ce && !prev_ce) begin
                grant_cnt++;
                if (exp_addr_q.size() == 0) check("grant_expected", 32'(exp_addr_q.size()), 32'd1);
                else check("grant_addr", m_addr, exp_addr_q.pop_front());
            end
            prev_ce = m_ce;
            if (!m_ce) begin
                wait_cnt = 0;
                m_ready  = 1'($urandom_range(0, 1));
                m_rdata  = $urandom;
            end else if (wait_cnt == wait_states) begin
                m_ready = 1'b1;
                m_rdata = rdata_of(m_addr);
            end else begin
                m_ready = 1'b0;
                wait_cnt++;
            end
        end
    end

    // ---------------- completion scoreboard ----------------
    initial begin
        logic cpu_pend;
        cpu_pend = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (cpu_pend) begin
                if (exp_cpu_q.size() == 0) check("cpu_done_expected", 32'(exp_cpu_q.size()), 32'd1);
                else check("cpu_dout", cpu_dout, exp_cpu_q.pop_front());
            end
            cpu_pend = rst_n && cpu_dce && !cpu_stall;
            if (ext_ack) begin
                ack_cnt++;
                if (exp_ext_q.size() == 0) check("ext_ack_expected", 32'(exp_ext_q.size()), 32'd1);
                else check("ext_rdata", ext_rdata, exp_ext_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_access(input logic [31:0] addr, input logic [3:0] we,
                              input logic [3:0] dre, input logic [31:0] din, input int waits);
        int cnt;
        @(negedge clk);
        wait_states = waits;
        cpu_daddr = addr;
        cpu_we    = we;
        cpu_dre   = dre;
        cpu_din   = din;
        cpu_dce   = 1'b1;
        exp_addr_q.push_back(addr);
        exp_cpu_q.push_back(rdata_of(addr));
        #1;
        cnt = 0;
        while (cpu_stall && cnt < 64) begin
            cnt++;
            @(negedge clk);
            #1;
            check("cpu_m_ce", 32'(m_ce), 32'd1);
            check("cpu_m_addr", m_addr, addr);
            check("cpu_m_we", 32'(m_we), 32'(we));
            check("cpu_m_re", 32'(m_re), 32'(dre));
            check("cpu_m_wdata", m_wdata, din);
        end
        if (cnt >= 64) check("cpu_stall_timeout", 32'(cnt), 32'd0);
        check("cpu_stall_cycles", 32'(cnt), 32'(waits + 1));
        @(negedge clk);
        cpu_dce = 1'b0;
        cpu_we  = '0;
        #1;
        check("cpu_m_ce_after", 32'(m_ce), 32'd0);
    endtask

    task automatic ext_access(input logic [31:0] addr, input logic [3:0] we,
                              input logic [31:0] wdata, input int waits);
        int cnt;
        @(negedge clk);
        wait_states = waits;
        ext_addr  = addr;
        ext_we    = we;
        ext_wdata = wdata;
        ext_req   = 1'b1;
        exp_addr_q.push_back(addr);
        exp_ext_q.push_back(rdata_of(addr));
        cnt = 1;
        while (!ext_ack && cnt < 64) begin
            @(negedge clk);
            #1;
            cnt++;
            if (!ext_ack) begin
                check("ext_m_addr", m_addr, addr);
                check("ext_m_we", 32'(m_we), 32'(we));
                check("ext_m_re", 32'(m_re), (we == 4'h0) ? 32'hF : 32'h0);
                check("ext_m_wdata", m_wdata, wdata);
            end
        end
        check("ext_ack_latency", 32'(cnt), 32'(waits + 3));
        // ext_req still held through the ack cycle and the one after
        @(negedge clk);
        #1;
        check("ext_ack_one_cycle", 32'(ext_ack), 32'd0);
        check("ext_no_regrant", 32'(m_ce), 32'd0);
        ext_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        int base;
        logic ack_prev;

        rst_n = 1'b0;
        cpu_dce = 1'b0; cpu_daddr = '0; cpu_we = '0; cpu_dre = '0; cpu_din = '0;
        ext_req = 1'b0; ext_addr = '0; ext_we = '0; ext_wdata = '0;

        // reset state; stall follows cpu_dce even in reset
        #1;
        cpu_dce = 1'b1;
        #1;
        check("rst_stall_follows_dce", 32'(cpu_stall), 32'd1);
        cpu_dce = 1'b0;
        #1;
        check("rst_stall_low", 32'(cpu_stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_m_ce", 32'(m_ce), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_cpu_dout", cpu_dout, 32'd0);
        check("rst_ext_ack", 32'(ext_ack), 32'd0);
        check("rst_ext_rdata", ext_rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // zero-wait CPU load, then a store with 3 memory wait states
        cpu_access(32'h100, 4'h0, 4'hF, 32'h0, 0);
        cpu_access(32'h140, 4'b0100, 4'h0, 32'h00AB_0000, 3);
        for (int i = 0; i < 3; i++) begin
            cpu_access(32'($urandom_range(0, 255)) << 2, 4'h0, 4'hF, 32'h0, $urandom_range(0, 2));
        end

        // external write; ext_req kept high past completion
        ext_access(32'h200, 4'hF, 32'h12345678, 0);

        // both held continuously: CPU x4, EXT, CPU
        @(negedge clk);
        wait_states = 0;
        base = grant_cnt;
        cpu_daddr = 32'h300; cpu_dre = 4'hF; cpu_we = '0; cpu_dce = 1'b1;
        ext_addr = 32'h400; ext_we = '0; ext_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(32'h300);
            exp_cpu_q.push_back(rdata_of(32'h300));
        end
        exp_addr_q.push_back(32'h400);
        exp_ext_q.push_back(rdata_of(32'h400));
        exp_addr_q.push_back(32'h300);
        exp_cpu_q.push_back(rdata_of(32'h300));
        cnt = 0;
        while (grant_cnt < base + 6 && cnt < 200) begin
            @(negedge clk);
            #1;
            cnt++;
            if (ext_ack) ext_req = 1'b0;
        end
        check("burst_grants", 32'(grant_cnt - base), 32'd6);
        @(negedge clk);
        cpu_dce = 1'b0;
        ext_req = 1'b0;

        // CPU request arriving during an external read with wait states
        @(negedge clk);
        wait_states = 2;
        ext_addr = 32'h500; ext_we = '0; ext_req = 1'b1;
        exp_addr_q.push_back(32'h500);
        exp_ext_q.push_back(rdata_of(32'h500));
        exp_addr_q.push_back(32'h600);
        exp_cpu_q.push_back(rdata_of(32'h600));
        @(negedge clk);
        #1;
        check("ext_read_m_re", 32'(m_re), 32'hF);
        cpu_daddr = 32'h600; cpu_we = '0; cpu_dre = 4'h3; cpu_dce = 1'b1;
        #1;
        cnt = 0;
        ack_prev = 1'b0;
        while (cpu_stall && cnt < 64) begin
            cnt++;
            @(negedge clk);
            #1;
            if (ack_prev) begin
                check("cpu_grant_in_ack_cycle_ce", 32'(m_ce), 32'd1);
                check("cpu_grant_in_ack_cycle_addr", m_addr, 32'h600);
                ext_req = 1'b0;
            end
            ack_prev = ext_ack;
        end
        check("cpu_behind_ext_stall_cycles", 32'(cnt), 32'd6);
        @(negedge clk);
        cpu_dce = 1'b0;
        ext_req = 1'b0;

        // reset in the middle of a CPU access
        @(negedge clk);
        wait_states = 2;
        cpu_daddr = 32'h700; cpu_dre = 4'hF; cpu_we = '0; cpu_dce = 1'b1;
        exp_addr_q.push_back(32'h700);
        @(negedge clk);
        #1;
        check("rst_mid_busy", 32'(dbg_state), 32'(ST_CPU_BUSY));
        rst_n = 1'b0;
        cpu_dce = 1'b0;
        #1;
        check("rst_mid_m_ce", 32'(m_ce), 32'd0);
        check("rst_mid_m_addr", m_addr, 32'd0);
        check("rst_mid_m_re", 32'(m_re), 32'd0);
        check("rst_mid_cpu_dout", cpu_dout, 32'd0);
        check("rst_mid_ext_rdata", ext_rdata, 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("post_rst_cpu_dout", cpu_dout, 32'd0);
        check("post_rst_m_ce", 32'(m_ce), 32'd0);
        check("post_rst_ext_ack", 32'(ext_ack), 32'd0);

        repeat (3) @(negedge clk);
        #3;
        check("ext_ack_total", 32'(ack_cnt), 32'd3);
        check("grant_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("cpu_q_empty", 32'(exp_cpu_q.size()), 32'd0);
        check("ext_q_empty", 32'(exp_ext_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the single data-memory port. It sits between the MEM stage's data-access outputs and the data RAM/bus, and shares that port with an external requester (program loader / debug port). It runs each access as a multi-cycle transaction against a memory that answers with `m_ready`. While a CPU access is pending it stalls the pipeline, and it bounds CPU starvation of the external port with a burst counter.

## Interface
- `MAX_CPU_BURST`, default 4: consecutive CPU grants allowed while `ext_req` is pending before the external port is forced in (range 1–15).
- `cpu_clk_50M`  in  1  clock; all state updates on the rising edge.
- `cpu_rst_n`  in  1  reset; asynchronous, active-low.
- `cpu_dce`  in  1  MEM-stage access request; held stable while `cpu_stall`=1.
- `cpu_daddr`  in  32  CPU byte address.
- `cpu_we`  in  4  CPU byte write enables; nonzero means store.
- `cpu_dre`  in  4  CPU byte read enables.
- `cpu_din`  in  32  CPU store data, already byte-lane aligned.
- `cpu_stall`  out  1  pipeline stall request (combinational).
- `cpu_dout`  out  32  load data (registered).
- `ext_req`  in  1  external request; hold high with fields stable until `ext_ack`.
- `ext_addr`  in  32  external address.
- `ext_we`  in  4  external byte write enables; 0 means read.
- `ext_wdata`  in  32  external write data.
- `ext_ack`  out  1  one-cycle completion pulse.
- `ext_rdata`  out  32  external read data; valid while `ext_ack`=1.
- `m_ce`  out  1  memory transaction active.
- `m_addr`  out  32  memory address.
- `m_we`  out  4  memory byte write enables.
- `m_re`  out  4  memory byte read enables (all ones for external reads).
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory read data; valid with `m_ready`.
- `m_ready`  in  1  memory completion; sampled only while `m_ce`=1.

## Operation
- FSM states: IDLE, CPU_BUSY, EXT_BUSY.
- IDLE, grant decision:
  - The external request counts as eligible only when `ext_req`=1 and `ext_ack`=0. The `ext_ack` mask prevents re-granting a request whose ack is in flight.
  - If both requesters are active, the CPU wins unless `streak`==`MAX_CPU_BURST`, in which case the external port wins.
- On grant, `m_*` registers load the winner's fields and `m_ce`←1, then the FSM goes to CPU_BUSY or EXT_BUSY.
- BUSY states:
  - `m_*` are held constant.
  - When `m_ready`=1, `m_ce`←0 and the FSM returns to IDLE at that edge.
  - CPU completion: `cpu_dout`←`m_rdata` (loaded on reads and writes).
  - External completion: `ext_rdata`←`m_rdata`, `ext_ack`←1 for exactly one cycle.
- `cpu_stall` = `cpu_dce` & ~(state==CPU_BUSY & `m_ready`). This covers the IDLE cycle, waiting behind an EXT_BUSY access, and memory wait states.
- `streak` is a 4-bit saturating counter:
  - increments on each CPU grant made while `ext_req`=1;
  - clears on an external grant, or in any cycle where `ext_req`=0.
- `cpu_dout` and `ext_rdata` hold their values between completions.

## Timing
- Reset values (asynchronous): state IDLE, `streak` 0, and `m_ce`, `m_addr`, `m_we`, `m_re`, `m_wdata`, `cpu_dout`, `ext_ack`, `ext_rdata` all 0. `cpu_stall` follows `cpu_dce` (the FSM is in IDLE).
- CPU access with zero-wait memory:
  - cycle 0: `cpu_dce`=1 in IDLE, stall=1;
  - cycle 1: CPU_BUSY, `m_ready`=1, stall=0;
  - cycle 2: `cpu_dout` is valid.
- Each memory wait state adds one stall cycle.
- External access: `ext_ack` is asserted in the cycle after `m_ready`. The minimum request-to-ack time is 3 cycles.
- A CPU request that arrives during EXT_BUSY waits. It is granted in the IDLE cycle that coincides with `ext_ack`, because the external port is masked then.
- Reset asserted mid-transaction: the access is abandoned immediately, `m_ce`=0, and no ack or `cpu_dout` update is produced.
- `m_ready` while `m_ce`=0 is ignored.

## Structure
- Widths use the shared `defines.v` buses: `DATA_ADDR_BUS`, `DATA_BUS`, `DATA_WE_BUS`.
- Add the FSM state encodings (2-bit) and the `MAX_CPU_BURST` default there as constants.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then `cpu_dce`=1, `cpu_dre`=4'hF, `cpu_daddr`=32'h100, zero-wait memory returning 32'hDEADBEEF → `m_ce` high in cycle 1 with `m_addr`=32'h100, `cpu_stall` high in cycle 0 only, `cpu_dout`=32'hDEADBEEF in cycle 2.
- CPU store `cpu_we`=4'b0100 with memory holding `m_ready` low for 3 cycles → `m_*` stable throughout, `cpu_stall` high for 4 cycles, then low.
- `ext_req` write (`ext_addr`=32'h200, `ext_wdata`=32'h12345678, `ext_we`=4'hF) with `ext_req` held high after completion → exactly one `ext_ack` pulse, and no second grant while ack=1.
- `cpu_dce` and `ext_req` both held continuously, `MAX_CPU_BURST`=4 → grant sequence CPU, CPU, CPU, CPU, EXT, CPU, …
- `cpu_dce` raised during EXT_BUSY → CPU granted in the IDLE/ack cycle, and `cpu_stall` stays high until the CPU's `m_ready`.
- `cpu_rst_n` pulsed low during CPU_BUSY → all outputs 0 within the same cycle, FSM in IDLE, and no stale `cpu_dout` update after release.
